// File: rtl/montgomery_mul_param_if.sv
// Operand/result bundle between the exponentiation controller and the Montgomery multiplier.
// The controller drives the master side; the multiplier is the slave.
interface montgomery_mul_param_if #(
    parameter int unsigned WIDTH = 2048
);
    logic             START;
    logic [WIDTH-1:0] X;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] N;
    logic [WIDTH-1:0] O;
    logic             BUSY;
    logic             DONE;
    logic             ERR;

    modport master (output START, X, Y, N, input O, BUSY, DONE, ERR);
    modport slave  (input START, X, Y, N, output O, BUSY, DONE, ERR);
endinterface

// File: rtl/montgomery_mul_param.sv
// Radix-2 / radix-4 Montgomery multiplier: O = X*Y*2^-WIDTH mod N.
// Operands are captured at start, then one digit is consumed per cycle, then a final >= N correction.
module montgomery_mul_param #(
    parameter int unsigned WIDTH      = 2048,
    parameter int unsigned DIGIT_BITS = 1,
    parameter int unsigned CNT_BITS   = 12
) (
    input logic                   clk,
    input logic                   rst,
    montgomery_mul_param_if.slave bus
);
    localparam int unsigned AW    = WIDTH + 3;
    localparam int unsigned ITERS = WIDTH / DIGIT_BITS;

    typedef enum logic [1:0] {StIdle, StCalc, StCorr, StFin} state_e;

    state_e                state_q;
    logic [WIDTH-1:0]      x_q;
    logic [WIDTH-1:0]      y_q;
    logic [WIDTH-1:0]      n_q;
    logic [AW-1:0]         a_q;
    logic [CNT_BITS-1:0]   k_q;
    logic [WIDTH-1:0]      o_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;

    logic [DIGIT_BITS-1:0] digit;
    logic [AW-1:0]         y_ext;
    logic [AW-1:0]         n_ext;
    logic [AW-1:0]         t;
    logic [AW-1:0]         u;
    logic [1:0]            q;
    logic [1:0]            nprime;
    logic [AW-1:0]         a_d;
    logic [WIDTH-1:0]      o_corr;

    always_comb begin
        digit  = x_q[DIGIT_BITS-1:0];
        y_ext  = {3'b000, y_q};
        n_ext  = {3'b000, n_q};
        t      = a_q;
        for (int i = 0; i < int'(DIGIT_BITS); i++) begin
            if (digit[i]) t = t + (y_ext << i);
        end
        // -n^-1 mod 4 is 3 for n = 1 mod 4 and 1 for n = 3 mod 4.
        nprime = n_q[1] ? 2'd1 : 2'd3;
        if (DIGIT_BITS == 1) begin
            q = {1'b0, t[0]};
        end else begin
            q = t[1:0] * nprime;
        end
        u = t;
        for (int i = 0; i < int'(DIGIT_BITS); i++) begin
            if (q[i]) u = u + (n_ext << i);
        end
        a_d    = u >> DIGIT_BITS;
        o_corr = (a_q >= n_ext) ? (a_q[WIDTH-1:0] - n_q) : a_q[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            y_q     <= '0;
            n_q     <= '0;
            a_q     <= '0;
            k_q     <= '0;
            o_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.START) begin
                        x_q   <= bus.X;
                        y_q   <= bus.Y;
                        n_q   <= bus.N;
                        a_q   <= '0;
                        k_q   <= '0;
                        o_q   <= '0;
                        err_q <= ~bus.N[0];
                        if (bus.N[0]) begin
                            busy_q  <= 1'b1;
                            state_q <= StCalc;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= StFin;
                        end
                    end
                end
                StCalc: begin
                    a_q <= a_d;
                    // Shifting x keeps the current digit at the bottom, avoiding a wide index mux.
                    x_q <= x_q >> DIGIT_BITS;
                    k_q <= k_q + 1'b1;
                    if (k_q == CNT_BITS'(ITERS - 1)) state_q <= StCorr;
                end
                StCorr: begin
                    o_q     <= o_corr;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= StFin;
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.O    = o_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.ERR  = err_q;
endmodule

// File: tb/tb_montgomery_mul_param.sv
// Directed bench for two 8-bit multipliers (radix-2 and radix-4) sharing clock and reset,
// with a result scoreboard filled from an independent modular-arithmetic model.
module tb_montgomery_mul_param;
    localparam int unsigned W = 8;

    logic clk;
    logic rst;
    logic start1, start2;
    logic [W-1:0] x_drv, y_drv, n_drv;
    logic sel;

    montgomery_mul_param_if #(.WIDTH(W)) m_if1 ();
    montgomery_mul_param_if #(.WIDTH(W)) m_if2 ();

    assign m_if1.START = start1;
    assign m_if1.X     = x_drv;
    assign m_if1.Y     = y_drv;
    assign m_if1.N     = n_drv;
    assign m_if2.START = start2;
    assign m_if2.X     = x_drv;
    assign m_if2.Y     = y_drv;
    assign m_if2.N     = n_drv;

    montgomery_mul_param #(.WIDTH(W), .DIGIT_BITS(1), .CNT_BITS(12)) u_dut_r2 (
        .clk (clk),
        .rst (rst),
        .bus (m_if1)
    );

    montgomery_mul_param #(.WIDTH(W), .DIGIT_BITS(2), .CNT_BITS(12)) u_dut_r4 (
        .clk (clk),
        .rst (rst),
        .bus (m_if2)
    );

    wire         done_s = sel ? m_if2.DONE : m_if1.DONE;
    wire         busy_s = sel ? m_if2.BUSY : m_if1.BUSY;
    wire         err_s  = sel ? m_if2.ERR  : m_if1.ERR;
    wire [W-1:0] o_s    = sel ? m_if2.O    : m_if1.O;

    int checks = 0;
    int errors = 0;
    int done_cnt1 = 0;
    int done_cnt2 = 0;
    logic [W-1:0] exp_o_q[$];
    logic         exp_err_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m_if1.DONE) done_cnt1 <= done_cnt1 + 1;
        if (m_if2.DONE) done_cnt2 <= done_cnt2 + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // X*Y*R^-1 mod N with R = 2^W, by brute-force search for R^-1.
    function automatic int mont_ref(input int xv, input int yv, input int nv);
        int rinv = 0;
        if (nv % 2 == 0) return 0;
        for (int r = 0; r < nv; r++) begin
            if (((256 * r) % nv) == 1 % nv) begin
                rinv = r;
                break;
            end
        end
        return (((xv * yv) % nv) * rinv) % nv;
    endfunction

    task automatic set_start(input logic v);
        if (sel) start2 = v;
        else start1 = v;
    endtask

    task automatic run_op(input logic r4, input int xv, input int yv, input int nv,
                          input bit scramble, input bit pulse);
        int lat = 0;
        int busy_n = 0;
        int dc0;
        int exp_lat;
        logic [W-1:0] eo;
        logic ee;
        @(negedge clk);
        sel = r4;
        dc0 = r4 ? done_cnt2 : done_cnt1;
        exp_o_q.push_back(W'(mont_ref(xv, yv, nv)));
        exp_err_q.push_back(nv % 2 == 0);
        exp_lat = (nv % 2 == 0) ? 0 : (r4 ? 4 : 8) + 1;
        x_drv = W'(xv);
        y_drv = W'(yv);
        n_drv = W'(nv);
        set_start(1'b1);
        @(posedge clk);
        @(negedge clk);
        set_start(1'b0);
        // lat counts edges after the start edge before DONE is visible.
        while (!done_s && lat < 40) begin
            if (busy_s) busy_n++;
            if (scramble) begin
                x_drv = W'($urandom);
                y_drv = W'($urandom);
                n_drv = W'($urandom);
            end
            if (pulse) set_start(busy_s ? 1'($urandom_range(0, 1)) : 1'b0);
            @(negedge clk);
            lat++;
        end
        set_start(1'b0);
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_n, exp_lat);
        check("busy_at_done", busy_s, 1'b0);
        if (exp_o_q.size() > 0) begin
            eo = exp_o_q.pop_front();
            ee = exp_err_q.pop_front();
            check("result", o_s, eo);
            check("err", err_s, ee);
        end
        @(negedge clk);
        check("done_pulse_width", done_s, 1'b0);
        check("done_count", (r4 ? done_cnt2 : done_cnt1) - dc0, 1);
    endtask

    initial begin
        int dc0;
        rst = 1'b1;
        start1 = 1'b0;
        start2 = 1'b0;
        sel = 1'b0;
        x_drv = '0;
        y_drv = '0;
        n_drv = '0;
        repeat (3) @(negedge clk);
        check("rst_o_r2", m_if1.O, 0);
        check("rst_busy_r2", m_if1.BUSY, 0);
        check("rst_done_r2", m_if1.DONE, 0);
        check("rst_err_r2", m_if1.ERR, 0);
        check("rst_o_r4", m_if2.O, 0);
        check("rst_busy_r4", m_if2.BUSY, 0);
        rst = 1'b0;

        run_op(1'b0, 5, 7, 13, 1'b0, 1'b0);
        run_op(1'b1, 5, 7, 13, 1'b0, 1'b0);
        run_op(1'b0, 12, 12, 13, 1'b0, 1'b0);
        run_op(1'b1, 12, 12, 13, 1'b0, 1'b0);
        run_op(1'b0, 254, 254, 255, 1'b0, 1'b0);
        run_op(1'b1, 254, 254, 255, 1'b0, 1'b0);
        run_op(1'b0, 9, 13, 13, 1'b0, 1'b0);
        run_op(1'b1, 9, 13, 13, 1'b0, 1'b0);
        run_op(1'b0, 3, 5, 12, 1'b0, 1'b0);
        run_op(1'b0, 5, 7, 13, 1'b0, 1'b0);
        run_op(1'b1, 3, 5, 12, 1'b0, 1'b0);
        run_op(1'b1, 5, 7, 13, 1'b0, 1'b0);
        run_op(1'b0, 100, 201, 211, 1'b0, 1'b0);
        run_op(1'b1, 100, 201, 211, 1'b0, 1'b0);
        run_op(1'b0, 5, 7, 13, 1'b1, 1'b1);
        run_op(1'b1, 5, 7, 13, 1'b1, 1'b1);

        // Reset in the middle of CALC on the radix-2 unit.
        @(negedge clk);
        sel = 1'b0;
        dc0 = done_cnt1;
        x_drv = 8'd5;
        y_drv = 8'd7;
        n_drv = 8'd13;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        check("busy_before_rst", m_if1.BUSY, 1'b1);
        #2 rst = 1'b1;
        #1;
        check("rst_async_busy", m_if1.BUSY, 1'b0);
        check("rst_async_done", m_if1.DONE, 1'b0);
        check("rst_async_o", m_if1.O, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", done_cnt1 - dc0, 0);
        run_op(1'b0, 5, 7, 13, 1'b0, 1'b0);

        check("scoreboard_empty", exp_o_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
